// File: rtl/halut_decoder.sv
// halut_decoder -- one output column of a HALUT (hashed approximate LUT) matmul.
//
// The decoder takes the merged encoder stream of (codebook c, prototype k) pairs.
// It looks each pair up in a C*K-entry LUT of signed partial products, and sums
// C lookups into one row result. The result is offered on a valid/ready port.
//
// Build option:
//   HALUT_DECODER_SATURATE_EN  When defined, each accumulator add saturates to the
//                              AccWidth signed range. Otherwise the add wraps.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   c_addr_i    codebook index of incoming codeword
//   k_addr_i    prototype index of incoming codeword
//   valid_i     codeword present this cycle
//   decoder_i   run enable; low clears all run state (LUT kept)
//   waddr_i     LUT write address {c, k}
//   wdata_i     LUT write data (signed)
//   we_i        LUT write enable
//   result_o    signed accumulated row result
//   valid_o     result_o valid
//   ready_i     consumer accepts result_o
//   overflow_o  sticky: a completed row was dropped because of backpressure
module halut_decoder #(
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int DataTypeWidth = 16,
    parameter int TreeDepth     = $clog2(K),
    parameter int CAddrWidth    = $clog2(C),
    parameter int LutAddrWidth  = CAddrWidth + TreeDepth,
    parameter int AccWidth      = DataTypeWidth + CAddrWidth
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [CAddrWidth-1:0]           c_addr_i,
    input  logic [TreeDepth-1:0]            k_addr_i,
    input  logic                            valid_i,
    input  logic                            decoder_i,
    input  logic [LutAddrWidth-1:0]         waddr_i,
    input  logic signed [DataTypeWidth-1:0] wdata_i,
    input  logic                            we_i,
    output logic signed [AccWidth-1:0]      result_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            overflow_o
);

    localparam logic [CAddrWidth-1:0] CntLast = CAddrWidth'(C - 1);

    // Accumulator add: the saturating or the wrapping variant, chosen at build time.
    function automatic logic signed [AccWidth-1:0] acc_add(
        input logic signed [AccWidth-1:0] a,
        input logic signed [AccWidth-1:0] b
    );
`ifdef HALUT_DECODER_SATURATE_EN
        logic [AccWidth:0] wide;
        wide = {a[AccWidth-1], a} + {b[AccWidth-1], b};
        // The two top bits disagree only when the true sum is outside the AccWidth range.
        if (wide[AccWidth] != wide[AccWidth-1])
            return wide[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                  : {1'b0, {(AccWidth-1){1'b1}}};
        return wide[AccWidth-1:0];
`else
        return a + b;
`endif
    endfunction

    // The LUT memory has no reset, and writes are accepted in any state.
    logic signed [DataTypeWidth-1:0] lut_mem [C*K];

    always_ff @(posedge clk_i) begin
        if (we_i)
            lut_mem[waddr_i] <= wdata_i;
    end

    // ---- Stage 1: register the incoming codeword ----
    logic [CAddrWidth-1:0] c_p1;
    logic [TreeDepth-1:0]  k_p1;
    logic                  vld_p1;

    always_ff @(posedge clk_i) begin
        c_p1 <= c_addr_i;
        k_p1 <= k_addr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= decoder_i & valid_i;
    end

    // ---- Stage 2: LUT read, sign-extend, accumulate ----
    logic signed [DataTypeWidth-1:0] lut_rd_p1;
    logic signed [AccWidth-1:0]      acc_p2;
    logic signed [AccWidth-1:0]      sum_p1;
    logic [CAddrWidth-1:0]           cnt_p2;
    logic                            done_p1;

    // The read is combinational from the flop array. A write on the same edge
    // therefore is not yet visible, so the old data is read.
    assign lut_rd_p1 = lut_mem[{c_p1, k_p1}];
    assign sum_p1    = acc_add(acc_p2, AccWidth'(lut_rd_p1));
    // The row ends on the C-th lookup by count. The c index order is not used.
    assign done_p1   = vld_p1 && (cnt_p2 == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end else if (!decoder_i) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
        end else if (vld_p1) begin
            if (done_p1) begin
                acc_p2 <= '0;
                cnt_p2 <= '0;
            end else begin
                acc_p2 <= sum_p1;
                cnt_p2 <= cnt_p2 + 1'b1;
            end
        end
    end

    // ---- Output register and valid/ready handshake ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o   <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (!decoder_i) begin
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (done_p1) begin
            if (valid_o && !ready_i) begin
                // The held result was not consumed yet, so the new row is dropped.
                overflow_o <= 1'b1;
            end else begin
                // This covers an empty slot and also a handshake in this same cycle.
                result_o <= sum_p1;
                valid_o  <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_halut_decoder.sv
// Directed testbench for halut_decoder. It uses a default-width instance and an
// AccWidth=16 instance. Both instances share all inputs.
module tb_halut_decoder;

    logic        clk;
    logic        rst_n;
    logic [4:0]  c_addr;
    logic [3:0]  k_addr;
    logic        valid;
    logic        decoder;
    logic [8:0]  waddr;
    logic [15:0] wdata;
    logic        we;
    logic        ready;
    logic [20:0] result;
    logic        valid_o;
    logic        overflow;
    logic [15:0] result16;
    logic        valid16;
    logic        overflow16;

    int n_checks = 0;
    int n_fail   = 0;

    halut_decoder dut (
        .clk_i(clk), .rst_ni(rst_n), .c_addr_i(c_addr), .k_addr_i(k_addr),
        .valid_i(valid), .decoder_i(decoder), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .result_o(result), .valid_o(valid_o), .ready_i(ready),
        .overflow_o(overflow)
    );

    halut_decoder #(.AccWidth(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .c_addr_i(c_addr), .k_addr_i(k_addr),
        .valid_i(valid), .decoder_i(decoder), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .result_o(result16), .valid_o(valid16), .ready_i(ready),
        .overflow_o(overflow16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: value=c, 1: all 0xFFFF, 2: value=k, 3: all 1, 4: all 0x7FFF
    task automatic load_lut(input int mode);
        for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 16; k++) begin
                waddr = {5'(c), 4'(k)};
                case (mode)
                    0: wdata = 16'(c);
                    1: wdata = 16'hFFFF;
                    2: wdata = 16'(k);
                    3: wdata = 16'd1;
                    default: wdata = 16'h7FFF;
                endcase
                we = 1'b1;
                tick();
            end
        end
        we = 1'b0;
    endtask

    task automatic feed_row(input int kval);
        for (int i = 0; i < 32; i++) begin
            c_addr = 5'(i);
            k_addr = 4'(kval);
            valid  = 1'b1;
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (result !== 21'd0) begin n_fail++; $display("FAIL reset_result got=%h required=%h", result, 21'd0); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b required=0", valid_o); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b required=0", overflow); end
        n_checks++; if (result16 !== 16'd0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_dut16 got=%h/%b required=0/0", result16, valid16); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_row;
        load_lut(0);
        ready = 1'b1;
        feed_row(5);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b required=0", valid_o); end
        tick();
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b required=1", valid_o); end
        n_checks++; if (result !== 21'd496) begin n_fail++; $display("FAIL basic_result got=%0d required=496", result); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%b required=0", valid_o); end
    endtask

    task automatic test_negative_gaps;
        int waited;
        load_lut(1);
        ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            repeat (i % 4) tick();
            c_addr = 5'(i);
            k_addr = 4'((i * 7) % 16);
            valid  = 1'b1;
            tick();
            valid = 1'b0;
        end
        waited = 0;
        while (valid_o !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL neg_timeout got valid=%b required=1", valid_o); end
        n_checks++; if (result !== 21'h1FFFE0) begin n_fail++; $display("FAIL neg_result got=%h required=1fffe0", result); end
        n_checks++; if (result16 !== 16'hFFE0) begin n_fail++; $display("FAIL neg_result16 got=%h required=ffe0", result16); end
        tick();
    endtask

    task automatic test_backpressure;
        load_lut(2);
        decoder = 1'b0; tick(); decoder = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            c_addr = 5'(i % 32);
            k_addr = (i < 32) ? 4'd1 : 4'd2;
            valid  = 1'b1;
            tick();
            if (i == 32) begin
                n_checks++; if (valid_o !== 1'b1 || result !== 21'd32) begin n_fail++; $display("FAIL bp_rowA got=%0d/%b required=32/1", result, valid_o); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_early_overflow got=%b required=0", overflow); end
            end
        end
        valid = 1'b0;
        tick();
        n_checks++; if (result !== 21'd32 || valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_held got=%0d/%b required=32/1", result, valid_o); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got=%b required=1", overflow); end
        ready = 1'b1;
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs got=%b required=0", valid_o); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got=%b required=1", overflow); end
        decoder = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_clear got=%b required=0", overflow); end
        decoder = 1'b1;
    endtask

    task automatic test_handshake_collision;
        ready = 1'b0;
        feed_row(1);
        tick();
        n_checks++; if (valid_o !== 1'b1 || result !== 21'd32) begin n_fail++; $display("FAIL coll_first got=%0d/%b required=32/1", result, valid_o); end
        feed_row(2);
        ready = 1'b1;
        tick();
        n_checks++; if (valid_o !== 1'b1 || result !== 21'd64) begin n_fail++; $display("FAIL coll_new got=%0d/%b required=64/1", result, valid_o); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL coll_overflow got=%b required=0", overflow); end
        tick();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL coll_drop got=%b required=0", valid_o); end
    endtask

    task automatic test_abort_restart;
        int seen;
        load_lut(3);
        ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            c_addr = 5'(i); k_addr = 4'd0; valid = 1'b1;
            tick();
            if (valid_o === 1'b1) seen++;
        end
        // This valid_i is presented while the decoder is disabled and must not be counted.
        decoder = 1'b0;
        tick();
        if (valid_o === 1'b1) seen++;
        decoder = 1'b1;
        for (int i = 0; i < 32; i++) begin
            c_addr = 5'(i); k_addr = 4'd3; valid = 1'b1;
            tick();
            if (valid_o === 1'b1) seen++;
        end
        valid = 1'b0;
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_early got=%0d valids required=0", seen); end
        tick();
        n_checks++; if (valid_o !== 1'b1 || result !== 21'd32) begin n_fail++; $display("FAIL abort_result got=%0d/%b required=32/1", result, valid_o); end
        tick();
    endtask

    task automatic test_saturation;
        logic [15:0] exp16;
`ifdef HALUT_DECODER_SATURATE_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'hFFE0;
`endif
        load_lut(4);
        ready = 1'b1;
        feed_row(9);
        tick();
        n_checks++; if (valid_o !== 1'b1 || result !== 21'h0FFFE0) begin n_fail++; $display("FAIL sat_wide got=%h/%b required=0fffe0/1", result, valid_o); end
        n_checks++; if (valid16 !== 1'b1 || result16 !== exp16) begin n_fail++; $display("FAIL sat_narrow got=%h/%b required=%h/1", result16, valid16, exp16); end
        tick();
    endtask

    task automatic test_reset_mid_row;
        load_lut(3);
        ready = 1'b0;
        feed_row(0);
        feed_row(1);
        for (int i = 0; i < 20; i++) begin
            c_addr = 5'(i); k_addr = 4'd2; valid = 1'b1;
            tick();
        end
        n_checks++; if (valid_o !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%b/%b required=1/1", valid_o, overflow); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (result !== 21'd0 || valid_o !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_async got=%h/%b/%b required=0/0/0", result, valid_o, overflow); end
        n_checks++; if (result16 !== 16'd0 || valid16 !== 1'b0 || overflow16 !== 1'b0) begin n_fail++; $display("FAIL rst_async16 got=%h/%b/%b required=0/0/0", result16, valid16, overflow16); end
        valid = 1'b0;
        tick();
        rst_n = 1'b1;
        load_lut(0);
        ready = 1'b1;
        feed_row(7);
        tick();
        n_checks++; if (valid_o !== 1'b1 || result !== 21'd496) begin n_fail++; $display("FAIL rst_recover got=%0d/%b required=496/1", result, valid_o); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; c_addr = '0; k_addr = '0; valid = 1'b0; decoder = 1'b1;
        waddr = '0; wdata = '0; we = 1'b0; ready = 1'b1;
        test_reset();
        test_basic_row();
        test_negative_gaps();
        test_backpressure();
        test_handshake_collision();
        test_abort_restart();
        test_saturation();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
